// File: rtl/pool1_streamer.sv
// Captures the pooled layer-1 maps on start and streams them out one spatial
// position per beat (CH-bit channel vector) in raster order over valid/ready.
module pool1_streamer #(
  parameter int CH = 20,
  parameter int H  = 12,
  parameter int W  = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   fmaps_in [0:CH-1][0:H-1][0:W-1],
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CH-1:0]          out_data,
  output logic [$clog2(H)-1:0]   out_row,
  output logic [$clog2(W)-1:0]   out_col,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done,
  output logic                   dbg_state
);

  localparam int RW = $clog2(H);
  localparam int CW = $clog2(W);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic          snap [0:CH-1][0:H-1][0:W-1];
  logic          capture;
  logic          xfer;
  logic          at_last;

  // Handshake: a beat moves on any rising edge where out_valid && out_ready;
  // while out_valid is high and out_ready low every out_* signal holds.
  assign capture   = (state == IDLE) && start;
  assign xfer      = (state == SEND) && out_ready;
  assign at_last   = (row == RW'(H - 1)) && (col == CW'(W - 1));
  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    busy      = 1'b0;
    out_data  = '0;
    out_row   = '0;
    out_col   = '0;
    out_last  = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = SEND;
      end
      SEND: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_row   = row;
        out_col   = col;
        out_last  = at_last;
        for (int c = 0; c < CH; c++) out_data[c] = snap[c][row][col];
        if (out_ready && at_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      row   <= '0;
      col   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= xfer && at_last;
      if (capture || (xfer && at_last)) begin
        row <= '0;
        col <= '0;
      end else if (xfer) begin
        if (col == CW'(W - 1)) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // Snapshot has no reset; its contents only matter after a capture.
  always_ff @(posedge clk) begin
    if (!rst && capture) snap <= fmaps_in;
  end

endmodule

// File: tb/tb_pool1_streamer.sv
// Directed bench for pool1_streamer: reset, full frame, backpressure, start
// while busy, back-to-back frames and reset mid-frame.
`timescale 1ns/1ps
module tb_pool1_streamer;

  localparam int CH = 20;
  localparam int H  = 12;
  localparam int W  = 12;
  localparam int NB = H * W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          out_ready = 1'b0;
  logic          fmaps [0:CH-1][0:H-1][0:W-1];
  logic          out_valid, out_last, busy, done, dbg_state;
  logic [CH-1:0] out_data;
  logic [3:0]    out_row, out_col;

  always #5 clk = ~clk;

  pool1_streamer #(.CH(CH), .H(H), .W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .fmaps_in(fmaps),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_last(out_last),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  logic [CH-1:0] exp_q[$];
  logic [CH-1:0] got_q[$];
  int            got_pos_q[$];
  logic          got_last_q[$];
  int            first_cyc, done_cyc, stall_bad, done_seen;
  bit            timed_out, hook_fired;
  int            hook_kind = 0;
  int            hook_beat = -1;
  int            hook_map = 0;

  // Map patterns: 0 checkerboard (c+r+k)&1, 1 its inverse, 2 all ones, 3 irregular.
  function automatic logic pat(input int kind, input int c, input int r, input int k);
    case (kind)
      0:       return ((c + r + k) % 2) == 1;
      1:       return ((c + r + k) % 2) == 0;
      2:       return 1'b1;
      default: return ((c * 3 + r * 5 + k * 7) % 5) < 2;
    endcase
  endfunction

  task automatic load_maps(input int kind);
    for (int c = 0; c < CH; c++)
      for (int r = 0; r < H; r++)
        for (int k = 0; k < W; k++)
          fmaps[c][r][k] = pat(kind, c, r, k);
  endtask

  task automatic build_exp(input int kind);
    logic [CH-1:0] v;
    exp_q.delete();
    for (int r = 0; r < H; r++)
      for (int k = 0; k < W; k++) begin
        for (int c = 0; c < CH; c++) v[c] = pat(kind, c, r, k);
        exp_q.push_back(v);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int kind);
    load_maps(kind);
    build_exp(kind);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Drives out_ready (pct % high) and records every transferred beat. Returns
  // in the done cycle, right after a reset hook fires, or on cycle budget.
  task automatic collect(input int pct);
    logic [29:0] held;
    bit          stalled;
    got_q.delete(); got_pos_q.delete(); got_last_q.delete();
    first_cyc = -1; done_cyc = -1; stall_bad = 0;
    timed_out = 0; hook_fired = 0; stalled = 0; held = '0;
    for (int n = 0; n < 3000; n++) begin
      start = 1'b0;
      if (done) begin
        done_cyc = n;
        done_seen++;
        return;
      end
      if (out_valid && first_cyc < 0) first_cyc = n;
      if (stalled && {out_valid, out_data, out_row, out_col, out_last} !== held) stall_bad++;
      held = {out_valid, out_data, out_row, out_col, out_last};
      if (!hook_fired && out_valid && (int'(out_row) * W + int'(out_col)) == hook_beat) begin
        if (hook_kind == 1) begin
          load_maps(hook_map);
          start = 1'b1;
          hook_fired = 1;
        end else if (hook_kind == 2) begin
          rst = 1'b1;
          hook_fired = 1;
          step();
          return;
        end
      end
      out_ready = ($urandom_range(99) < pct);
      stalled = out_valid && !out_ready;
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        got_pos_q.push_back(int'(out_row) * 16 + int'(out_col));
        got_last_q.push_back(out_last);
      end
      step();
    end
    timed_out = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    load_maps(0);
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({out_valid, out_data, out_row, out_col, out_last, busy, done} !== '0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: valid=%b data=%h row=%0d col=%0d last=%b busy=%b done=%b, required all 0",
                 i, out_valid, out_data, out_row, out_col, out_last, busy, done);
      end
    end
  endtask

  task automatic test_full_frame();
    done_seen = 0;
    do_start(0);
    collect(100);
    checks++;
    if (timed_out || got_q.size() != NB) begin
      errors++;
      $display("FAIL full_frame_count: beats=%0d timeout=%0d, required %0d beats", got_q.size(), timed_out, NB);
    end
    checks++;
    if (first_cyc != 0 || done_cyc - first_cyc + 1 != NB + 1) begin
      errors++;
      $display("FAIL full_frame_timing: first_valid=%0d frame_cycles=%0d, required 0 and %0d",
               first_cyc, done_cyc - first_cyc + 1, NB + 1);
    end
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL full_frame_done_cycle: valid=%b busy=%b done=%b, required 0 0 1", out_valid, busy, done);
    end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_pos_q[i] != (i / W) * 16 + i % W || got_last_q[i] !== (i == NB - 1)) begin
        errors++;
        $display("FAIL full_frame_beat %0d: data=%h pos=%0h last=%b, required data=%h pos=%0h last=%b",
                 i, got_q[i], got_pos_q[i], got_last_q[i], exp_q[i], (i / W) * 16 + i % W, i == NB - 1);
      end
    end
    step();
    checks++;
    if (done !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_frame_done_width: done=%b valid=%b, required 0 0", done, out_valid);
    end
  endtask

  task automatic test_backpressure();
    do_start(3);
    for (int c = 0; c < CH; c++)
      for (int r = 0; r < H; r++)
        for (int k = 0; k < W; k++)
          fmaps[c][r][k] = ~fmaps[c][r][k];
    collect(50);
    checks++;
    if (timed_out || got_q.size() != NB) begin
      errors++;
      $display("FAIL bp_count: beats=%0d timeout=%0d, required %0d beats", got_q.size(), timed_out, NB);
    end
    checks++;
    if (stall_bad != 0) begin
      errors++;
      $display("FAIL bp_stall_stable: changed_during_stall=%0d, required 0", stall_bad);
    end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_pos_q[i] != (i / W) * 16 + i % W || got_last_q[i] !== (i == NB - 1)) begin
        errors++;
        $display("FAIL bp_beat %0d: data=%h pos=%0h last=%b, required data=%h pos=%0h last=%b",
                 i, got_q[i], got_pos_q[i], got_last_q[i], exp_q[i], (i / W) * 16 + i % W, i == NB - 1);
      end
    end
    step();
  endtask

  task automatic test_start_busy();
    int extra_done, extra_valid;
    done_seen = 0;
    hook_kind = 1; hook_beat = 5 * W + 3; hook_map = 2;
    do_start(0);
    collect(100);
    hook_kind = 0; hook_beat = -1;
    checks++;
    if (!hook_fired || timed_out || got_q.size() != NB) begin
      errors++;
      $display("FAIL busy_start_count: hook=%0d beats=%0d timeout=%0d, required 1 %0d 0",
               hook_fired, got_q.size(), timed_out, NB);
    end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_pos_q[i] != (i / W) * 16 + i % W) begin
        errors++;
        $display("FAIL busy_start_beat %0d: data=%h pos=%0h, required data=%h pos=%0h",
                 i, got_q[i], got_pos_q[i], exp_q[i], (i / W) * 16 + i % W);
      end
    end
    extra_done = 0; extra_valid = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (done) extra_done++;
      if (out_valid) extra_valid++;
    end
    checks++;
    if (done_seen + extra_done != 1 || extra_valid != 0) begin
      errors++;
      $display("FAIL busy_start_done: done_pulses=%0d valid_after=%0d, required 1 and 0",
               done_seen + extra_done, extra_valid);
    end
  endtask

  task automatic test_back_to_back();
    do_start(0);
    collect(100);
    checks++;
    if (timed_out || done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_done: done=%b timeout=%0d, required 1 0", done, timed_out);
    end
    do_start(2);
    checks++;
    if (out_valid !== 1'b1 || out_row !== 4'd0 || out_col !== 4'd0) begin
      errors++;
      $display("FAIL b2b_resume: valid=%b row=%0d col=%0d, required 1 0 0", out_valid, out_row, out_col);
    end
    collect(100);
    checks++;
    if (timed_out || got_q.size() != NB) begin
      errors++;
      $display("FAIL b2b_count: beats=%0d timeout=%0d, required %0d", got_q.size(), timed_out, NB);
    end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== 20'hFFFFF || got_pos_q[i] != (i / W) * 16 + i % W) begin
        errors++;
        $display("FAIL b2b_beat %0d: data=%h pos=%0h, required data=fffff pos=%0h",
                 i, got_q[i], got_pos_q[i], (i / W) * 16 + i % W);
      end
    end
    step();
  endtask

  task automatic test_reset_mid();
    done_seen = 0;
    hook_kind = 2; hook_beat = 7 * W;
    do_start(0);
    collect(100);
    hook_kind = 0; hook_beat = -1;
    checks++;
    if (!hook_fired || got_q.size() != 7 * W) begin
      errors++;
      $display("FAIL midrst_hook: fired=%0d beats=%0d, required 1 %0d", hook_fired, got_q.size(), 7 * W);
    end
    checks++;
    if ({out_valid, out_data, out_row, out_col, out_last, busy, done} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: valid=%b data=%h row=%0d col=%0d last=%b busy=%b done=%b, required all 0",
               out_valid, out_data, out_row, out_col, out_last, busy, done);
    end
    rst = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midrst_idle: valid=%b busy=%b done=%b, required 0 0 0", out_valid, busy, done);
    end
    do_start(3);
    collect(100);
    checks++;
    if (timed_out || got_q.size() != NB || done_seen != 1) begin
      errors++;
      $display("FAIL midrst_restart: beats=%0d done_pulses=%0d timeout=%0d, required %0d 1 0",
               got_q.size(), done_seen, timed_out, NB);
    end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_pos_q[i] != (i / W) * 16 + i % W || got_last_q[i] !== (i == NB - 1)) begin
        errors++;
        $display("FAIL midrst_beat %0d: data=%h pos=%0h last=%b, required data=%h pos=%0h last=%b",
                 i, got_q[i], got_pos_q[i], got_last_q[i], exp_q[i], (i / W) * 16 + i % W, i == NB - 1);
      end
    end
    step();
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_backpressure();
    test_start_busy();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
